// File: rtl/tst_sg_sched_pkg.sv
// Shared types for the test-signal strobe scheduler.
//   state_t  : scheduler FSM states (IDLE / RUN / DRAIN)
//   strobe_t : bundle of the seven one-clock timing strobes
package tst_sg_sched_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int CYC_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2   // stop requested, finishing the current cycle
  } state_t;

  typedef struct packed {
    logic tno;
    logic tnc;
    logic tni;
    logic tki;
    logic tnp;
    logic tkp;
    logic tobm;
  } strobe_t;

endpackage

// File: rtl/tst_sg_sched_cnt.sv
// In-cycle counter c and cycle counter k for the strobe scheduler.
//   clr        : force both counters to 0 on the next clock (sequence launch)
//   en         : advance counters (scheduler active)
//   period     : cycle length in clocks; c counts 0..period-1
//   n_cyc      : cycles per frame; k counts 0..n_cyc-1
//   c_nxt/k_nxt: values the counters take at the next edge, so the
//                strobe registers can be loaded in step with c/k
//   cyc_end    : c is at the last clock of the cycle
//   frame_end  : last clock of the last cycle of the frame
module tst_sg_sched_cnt #(
  parameter int CNT_W = 16,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CYC_W-1:0] n_cyc,
  output logic [CNT_W-1:0] c_nxt,
  output logic [CYC_W-1:0] k_nxt,
  output logic             cyc_end,
  output logic             frame_end
);

  logic [CNT_W-1:0] c;
  logic [CYC_W-1:0] k;

  assign cyc_end   = (c == period - CNT_W'(1));
  assign frame_end = cyc_end && (k == n_cyc - CYC_W'(1));

  always_comb begin
    c_nxt = c;
    k_nxt = k;
    if (clr) begin
      c_nxt = '0;
      k_nxt = '0;
    end else if (en) begin
      if (cyc_end) begin
        c_nxt = '0;
        k_nxt = frame_end ? '0 : k + CYC_W'(1);
      end else begin
        c_nxt = c + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
      k <= '0;
    end else begin
      c <= c_nxt;
      k <= k_nxt;
    end
  end

endmodule

// File: rtl/tst_sg_sched.sv
// Radar timing-strobe scheduler feeding the test-signal selector.
// Runs programmed sounding cycles grouped into frames; the mux mode only
// changes at frame start so the selector never switches mid-cycle.
//   clk, rst_n        : clock, async active-low reset
//   start, stop       : 1-clk pulses; launch sequence / finish cycle then idle
//   t_emit/t_guard/t_recv/t_period/n_cyc : timing configuration
//   mode_req, mode_we : pending mux mode {upr2,upr1} and its load strobe
//   tno..tobm         : registered one-clock strobes
//   upr1, upr2        : active mux mode
//   busy              : sequence active (first TNC until back in IDLE)
//   cfg_err           : sticky flag for a rejected start configuration
module tst_sg_sched
  import tst_sg_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] t_emit,
  input  logic [CNT_W-1:0] t_guard,
  input  logic [CNT_W-1:0] t_recv,
  input  logic [CNT_W-1:0] t_period,
  input  logic [CYC_W-1:0] n_cyc,
  input  logic [1:0]       mode_req,
  input  logic             mode_we,
  output logic             TNO,
  output logic             TNC,
  output logic             TNI,
  output logic             TKI,
  output logic             TNP,
  output logic             TKP,
  output logic             TOBM,
  output logic             upr1,
  output logic             upr2,
  output logic             busy,
  output logic             cfg_err
);

  localparam int EXT_W = CNT_W + 2;

  state_t           state_q, state_d;
  strobe_t          strb_q, strb_d;
  logic [CNT_W-1:0] sh_emit, sh_guard, sh_recv, sh_period;
  logic [CYC_W-1:0] sh_ncyc;
  logic [CNT_W-1:0] emit_d, guard_d, recv_d, period_d;
  logic [CYC_W-1:0] ncyc_d;
  logic [1:0]       pend, upr;
  logic [CNT_W-1:0] c_nxt;
  logic [CYC_W-1:0] k_nxt;
  logic             cyc_end, frame_end;
  logic             launch, load, run_next, cfg_ok, start_req;
  logic [EXT_W-1:0] span, off_tki, off_tnp, off_tkp, c_ext;

  // Extra two bits keep the sum from wrapping for any 16-bit inputs.
  assign span   = EXT_W'(2) + {2'b00, t_emit} + {2'b00, t_guard} + {2'b00, t_recv};
  assign cfg_ok = (|t_emit) && (|t_guard) && (|t_recv) && (|n_cyc) &&
                  (span < {2'b00, t_period});
  assign start_req = start && !stop;

  tst_sg_sched_cnt #(.CNT_W(CNT_W), .CYC_W(CYC_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (launch),
    .en        (state_q != S_IDLE),
    .period    (sh_period),
    .n_cyc     (sh_ncyc),
    .c_nxt     (c_nxt),
    .k_nxt     (k_nxt),
    .cyc_end   (cyc_end),
    .frame_end (frame_end)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_req && cfg_ok) state_d = S_RUN;
      S_RUN: begin
        if (stop && cyc_end) state_d = S_IDLE;
        else if (stop)       state_d = S_DRAIN;
      end
      S_DRAIN: if (cyc_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: shadow selection and next-clock strobe values.
  // Strobes are decoded from the counter/config values of the next clock
  // so the registered strobe lines up with the clock where c matches.
  always_comb begin
    launch   = (state_q == S_IDLE) && (state_d == S_RUN);
    run_next = (state_d != S_IDLE);
    load     = launch || ((state_q != S_IDLE) && frame_end);
    emit_d   = load ? t_emit   : sh_emit;
    guard_d  = load ? t_guard  : sh_guard;
    recv_d   = load ? t_recv   : sh_recv;
    period_d = load ? t_period : sh_period;
    ncyc_d   = load ? n_cyc    : sh_ncyc;
    off_tki  = EXT_W'(1) + {2'b00, emit_d};
    off_tnp  = off_tki + {2'b00, guard_d};
    off_tkp  = off_tnp + {2'b00, recv_d};
    c_ext    = {2'b00, c_nxt};
    strb_d      = '0;
    strb_d.tnc  = run_next && (c_nxt == '0);
    strb_d.tno  = run_next && (c_nxt == '0) && (k_nxt == '0);
    strb_d.tni  = run_next && (c_nxt == CNT_W'(1));
    strb_d.tki  = run_next && (c_ext == off_tki);
    strb_d.tnp  = run_next && (c_ext == off_tnp);
    strb_d.tkp  = run_next && (c_ext == off_tkp);
    strb_d.tobm = run_next && (c_nxt == period_d - CNT_W'(1)) &&
                  (k_nxt == ncyc_d - CYC_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q    <= '0;
      sh_emit   <= '0;
      sh_guard  <= '0;
      sh_recv   <= '0;
      sh_period <= '0;
      sh_ncyc   <= '0;
      pend      <= '0;
      upr       <= '0;
      cfg_err   <= 1'b0;
    end else begin
      strb_q <= strb_d;
      if (load) begin
        sh_emit   <= t_emit;
        sh_guard  <= t_guard;
        sh_recv   <= t_recv;
        sh_period <= t_period;
        sh_ncyc   <= n_cyc;
      end
      // upr samples the old pending value, so a write landing on the
      // TNO clock only takes effect at the following frame.
      if (strb_d.tno) upr  <= pend;
      if (mode_we)    pend <= mode_req;
      if ((state_q == S_IDLE) && start_req) cfg_err <= !cfg_ok;
    end
  end

  assign TNO  = strb_q.tno;
  assign TNC  = strb_q.tnc;
  assign TNI  = strb_q.tni;
  assign TKI  = strb_q.tki;
  assign TNP  = strb_q.tnp;
  assign TKP  = strb_q.tkp;
  assign TOBM = strb_q.tobm;
  assign upr1 = upr[0];
  assign upr2 = upr[1];
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_tst_sg_sched.sv
module tb_tst_sg_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, mode_we = 1'b0;
  logic [15:0] t_emit = 16'd3, t_guard = 16'd2, t_recv = 16'd4, t_period = 16'd16;
  logic [7:0]  n_cyc = 8'd2;
  logic [1:0]  mode_req = 2'b00;
  logic        TNO, TNC, TNI, TKI, TNP, TKP, TOBM, upr1, upr2, busy, cfg_err;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: elapsed clocks since frame start, plus flags.
  bit   m_run, m_stop, m_err;
  int   m_t;
  int   sE, sG, sR, sP, sN;
  logic [1:0] m_pend, m_upr;

  tst_sg_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .t_emit(t_emit), .t_guard(t_guard), .t_recv(t_recv), .t_period(t_period),
    .n_cyc(n_cyc), .mode_req(mode_req), .mode_we(mode_we),
    .TNO(TNO), .TNC(TNC), .TNI(TNI), .TKI(TKI), .TNP(TNP), .TKP(TKP), .TOBM(TOBM),
    .upr1(upr1), .upr2(upr2), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task model_reset();
    m_run = 0; m_stop = 0; m_err = 0; m_t = 0;
    m_pend = 2'b00; m_upr = 2'b00;
    sE = 0; sG = 0; sR = 0; sP = 1; sN = 1;
  endtask

  task model_load();
    sE = int'(t_emit); sG = int'(t_guard); sR = int'(t_recv);
    sP = int'(t_period); sN = int'(n_cyc);
  endtask

  task model_step();
    logic [1:0] old_pend;
    bit ok;
    old_pend = m_pend;
    if (!m_run) begin
      if (start && !stop) begin
        ok = (t_emit != 0) && (t_guard != 0) && (t_recv != 0) && (n_cyc != 0) &&
             (2 + int'(t_emit) + int'(t_guard) + int'(t_recv) < int'(t_period));
        if (ok) begin
          m_run = 1; m_t = 0; m_stop = 0; m_err = 0; model_load();
        end else m_err = 1;
      end
    end else begin
      if ((m_t % sP == sP - 1) && (m_stop || stop)) begin
        m_run = 0; m_stop = 0;
      end else begin
        if (stop) m_stop = 1;
        m_t++;
        if (m_t == sP * sN) begin
          m_t = 0; model_load();
        end
      end
    end
    if (m_run && m_t == 0) m_upr = old_pend;
    if (mode_we) m_pend = mode_req;
  endtask

  task check_all();
    int c, k;
    c = m_t % sP; k = m_t / sP;
    chk("TNC",  TNC,  m_run && c == 0);
    chk("TNO",  TNO,  m_run && c == 0 && k == 0);
    chk("TNI",  TNI,  m_run && c == 1);
    chk("TKI",  TKI,  m_run && c == 1 + sE);
    chk("TNP",  TNP,  m_run && c == 1 + sE + sG);
    chk("TKP",  TKP,  m_run && c == 1 + sE + sG + sR);
    chk("TOBM", TOBM, m_run && c == sP - 1 && k == sN - 1);
    chk("busy", busy, m_run);
    chk("cfg_err", cfg_err, m_err);
    chk("upr", {upr2, upr1}, m_upr);
  endtask

  // One clock: DUT and model advance on the same edge, compare #1 later,
  // then clear the single-clock pulses on the falling edge.
  task tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all();
    @(negedge clk);
    start = 0; stop = 0; mode_we = 0;
  endtask

  task set_cfg(input int e, input int g, input int r, input int p, input int n);
    t_emit = 16'(e); t_guard = 16'(g); t_recv = 16'(r); t_period = 16'(p); n_cyc = 8'(n);
  endtask

  task drain();
    int guard;
    stop = 1;
    guard = 0;
    while (m_run && guard < 300) begin
      tick();
      guard++;
    end
    chk("drain_bound", m_run, 0);
  endtask

  initial begin
    int tki_pos, tkp_pos, tobm_pos, tno_cnt;
    bit seen_tobm;
    model_reset();
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1;
    tick();

    // Nominal timing: pending mode 01 applied at launch
    mode_req = 2'b01; mode_we = 1;
    tick();
    set_cfg(3, 2, 4, 16, 2);
    tki_pos = -1; tkp_pos = -1; tobm_pos = -1; tno_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      if (i == 0) start = 1;
      if (i == 7) start = 1;   // start while busy: must be ignored
      tick();
      if (TKI && tki_pos < 0) tki_pos = i;
      if (TKP && tkp_pos < 0) tkp_pos = i;
      if (TOBM && tobm_pos < 0) tobm_pos = i;
      if (TNO) tno_cnt++;
    end
    chk("tki_pos", tki_pos, 4);
    chk("tkp_pos", tkp_pos, 10);
    chk("tobm_pos", tobm_pos, 31);
    chk("tno_cnt", tno_cnt, 2);
    chk("upr_launch", {upr2, upr1}, 2'b01);
    drain();

    // Rejected configuration, then a valid start clears the flag
    set_cfg(3, 2, 4, 10, 2);
    start = 1;
    tick();
    chk("cfg_err_set", cfg_err, 1);
    repeat (3) tick();
    set_cfg(3, 2, 4, 16, 2);
    start = 1;
    tick();
    chk("cfg_err_clr", cfg_err, 0);

    // Mode written mid-frame, visible only from the next TNO clock
    for (int i = 1; i < 32; i++) begin
      if (i == 6) begin mode_req = 2'b10; mode_we = 1; end
      tick();
      if (i < 32) chk("upr_hold", {upr2, upr1}, 2'b01);
    end
    tick();
    chk("upr_new", {upr2, upr1}, 2'b10);
    drain();

    // Stop at c=5 of k=0: finish cycle, no TOBM
    start = 1;
    tick();
    seen_tobm = 0;
    for (int i = 1; i < 17; i++) begin
      if (i == 6) stop = 1;
      tick();
      if (TOBM) seen_tobm = 1;
      if (i == 15) chk("busy_c15", busy, 1);
    end
    chk("busy_after_stop", busy, 0);
    chk("no_tobm", seen_tobm, 0);

    // start+stop together in IDLE
    start = 1; stop = 1;
    tick();
    repeat (2) tick();
    chk("startstop_idle", busy, 0);

    // Async reset at the TKI clock
    start = 1;
    tick();
    for (int i = 0; i < 20 && !TKI; i++) tick();
    chk("tki_before_rst", TKI, 1);
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
    repeat (3) tick();

    // Randomized sequences against the model
    for (int r = 0; r < 30; r++) begin
      int e, g, rr, p, n;
      e = $urandom_range(1, 4); g = $urandom_range(1, 4); rr = $urandom_range(1, 4);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 4) == 0) p = 2 + e + g + rr - $urandom_range(0, 1);
      else p = 3 + e + g + rr + $urandom_range(0, 5);
      set_cfg(e, g, rr, p, n);
      start = 1;
      if ($urandom_range(0, 9) == 0) stop = 1;
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          mode_req = 2'($urandom_range(0, 3)); mode_we = 1;
        end
        if ($urandom_range(0, 19) == 0) start = 1;
        if ($urandom_range(0, 59) == 0) stop = 1;
        tick();
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
